pe_array_cfg_seq: RTL and testbench

//  Sequences the PE array's one-time configuration before each layer/tile pass.
//  - ID tables: fetches the YID/XID tag tables from a 1-cycle-latency ID table RAM and

---
 rtl/pe_cfg_pkg.sv | 34 +++
 rtl/pe_array_cfg_seq.sv | 154 +++++++++++++++
 tb/tb_pe_array_cfg_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pe_cfg_pkg.sv
// Shared types for the PE array configuration sequencer:
// state enum, ID table entry layout, default sizes, table depth helper.
package pe_cfg_pkg;

  localparam int DEF_ROW       = 6;
  localparam int DEF_COL       = 8;
  localparam int DEF_XID_BITS  = 6;
  localparam int DEF_YID_BITS  = 3;
  localparam int DEF_CFG_SIZE  = 4;
  localparam int DEF_ADDR_BITS = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_Y,
    S_LOAD_X,
    S_DRAIN,
    S_SET_LN,
    S_ENABLE,
    S_DONE
  } cfg_state_e;

  typedef struct packed {
    logic [DEF_XID_BITS-1:0] opsum;
    logic [DEF_XID_BITS-1:0] ipsum;
    logic [DEF_XID_BITS-1:0] filter;
    logic [DEF_XID_BITS-1:0] ifmap;
  } id_entry_t;

  // YID entries first, then one XID entry per PE.
  function automatic int id_tbl_depth(input int row, input int col);
    return row + row * col;
  endfunction

endpackage

// File: rtl/pe_array_cfg_seq.sv
// PE array config sequencer: scans YID/XID tables from a 1-cycle ID RAM,
// then strobes LN config, PE enable, and done. Ports: start/abort/done/busy
// to the controller, id_rd_* to the ID RAM, scan/LN/PE outputs to the array.
module pe_array_cfg_seq
  import pe_cfg_pkg::*;
#(
  parameter int NUMS_PE_ROW = DEF_ROW,
  parameter int NUMS_PE_COL = DEF_COL,
  parameter int XID_BITS    = DEF_XID_BITS,
  parameter int YID_BITS    = DEF_YID_BITS,
  parameter int CONFIG_SIZE = DEF_CFG_SIZE,
  parameter int ADDR_BITS   = DEF_ADDR_BITS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  input  logic                             reload_ids,
  input  logic [NUMS_PE_ROW-2:0]           ln_cfg,
  input  logic [CONFIG_SIZE-1:0]           pe_cfg,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0] pe_en_mask,
  output logic                             busy,
  output logic                             done,
  output logic                             id_rd_en,
  output logic [ADDR_BITS-1:0]             id_rd_addr,
  input  logic [4*XID_BITS-1:0]            id_rd_data,
  output logic                             set_YID,
  output logic                             set_XID,
  output logic [YID_BITS-1:0]              ifmap_YID_scan_out,
  output logic [YID_BITS-1:0]              filter_YID_scan_out,
  output logic [YID_BITS-1:0]              ipsum_YID_scan_out,
  output logic [YID_BITS-1:0]              opsum_YID_scan_out,
  output logic [XID_BITS-1:0]              ifmap_XID_scan_out,
  output logic [XID_BITS-1:0]              filter_XID_scan_out,
  output logic [XID_BITS-1:0]              ipsum_XID_scan_out,
  output logic [XID_BITS-1:0]              opsum_XID_scan_out,
  output logic                             set_LN,
  output logic [NUMS_PE_ROW-2:0]           LN_config_out,
  output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0] PE_en,
  output logic [CONFIG_SIZE-1:0]           PE_config
);

  localparam int NPE   = NUMS_PE_ROW * NUMS_PE_COL;
  localparam int DEPTH = id_tbl_depth(NUMS_PE_ROW, NUMS_PE_COL);
  localparam logic [ADDR_BITS-1:0] A_LAST_Y = ADDR_BITS'(NUMS_PE_ROW - 1);
  localparam logic [ADDR_BITS-1:0] A_LAST   = ADDR_BITS'(DEPTH - 1);

  if (DEPTH > (1 << ADDR_BITS)) begin : g_addr_chk
    $error("ADDR_BITS too narrow for ID table depth");
  end

  cfg_state_e               r_state, w_next;
  logic [ADDR_BITS-1:0]     r_addr;
  logic                     r_set_y, r_set_x;
  logic [NUMS_PE_ROW-2:0]   r_ln;
  logic [CONFIG_SIZE-1:0]   r_pe;
  logic [NPE-1:0]           r_mask;
  logic                     w_accept;
  logic                     w_rd_y, w_rd_x;

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_rd_y     = 1'b0;
    w_rd_x     = 1'b0;
    busy       = (r_state != S_IDLE);
    done       = 1'b0;
    set_LN     = 1'b0;
    PE_en      = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = reload_ids ? S_LOAD_Y : S_SET_LN;
        end
      end
      S_LOAD_Y: begin
        w_rd_y = 1'b1;
        if (r_addr == A_LAST_Y) w_next = S_LOAD_X;
      end
      S_LOAD_X: begin
        w_rd_x = 1'b1;
        if (r_addr == A_LAST) w_next = S_DRAIN;
      end
      S_DRAIN:  w_next = S_SET_LN;
      S_SET_LN: begin
        set_LN = 1'b1;
        w_next = S_ENABLE;
      end
      S_ENABLE: begin
        PE_en  = r_mask;
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
    if (abort) begin
      w_next   = S_IDLE;
      w_accept = 1'b0;
    end
  end

  assign id_rd_en   = w_rd_y | w_rd_x;
  assign id_rd_addr = id_rd_en ? r_addr : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_set_y <= 1'b0;
      r_set_x <= 1'b0;
      r_ln    <= '0;
      r_pe    <= '0;
      r_mask  <= '0;
    end else begin
      r_state <= w_next;
      // abort drops the read whose data would return next cycle
      r_set_y <= w_rd_y & ~abort;
      r_set_x <= w_rd_x & ~abort;
      if (w_accept) begin
        r_addr <= '0;
        r_ln   <= ln_cfg;
        r_pe   <= pe_cfg;
        r_mask <= pe_en_mask;
      end else if (id_rd_en && r_addr != '1) begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  assign set_YID       = r_set_y;
  assign set_XID       = r_set_x;
  assign LN_config_out = r_ln;
  assign PE_config     = r_pe;

  logic [XID_BITS-1:0] w_ifm, w_flt, w_ips, w_ops;
  assign w_ifm = id_rd_data[0*XID_BITS +: XID_BITS];
  assign w_flt = id_rd_data[1*XID_BITS +: XID_BITS];
  assign w_ips = id_rd_data[2*XID_BITS +: XID_BITS];
  assign w_ops = id_rd_data[3*XID_BITS +: XID_BITS];

  assign ifmap_YID_scan_out  = r_set_y ? w_ifm[YID_BITS-1:0] : '0;
  assign filter_YID_scan_out = r_set_y ? w_flt[YID_BITS-1:0] : '0;
  assign ipsum_YID_scan_out  = r_set_y ? w_ips[YID_BITS-1:0] : '0;
  assign opsum_YID_scan_out  = r_set_y ? w_ops[YID_BITS-1:0] : '0;
  assign ifmap_XID_scan_out  = r_set_x ? w_ifm : '0;
  assign filter_XID_scan_out = r_set_x ? w_flt : '0;
  assign ipsum_XID_scan_out  = r_set_x ? w_ips : '0;
  assign opsum_XID_scan_out  = r_set_x ? w_ops : '0;

endmodule

// File: tb/tb_pe_array_cfg_seq.sv
// Self-checking bench for pe_array_cfg_seq (6x8 array).
// Cycle-offset reference model; 1-cycle ID RAM model.
module tb_pe_array_cfg_seq;
  import pe_cfg_pkg::*;

  localparam int R  = 6;
  localparam int C  = 8;
  localparam int N  = R * C;
  localparam int XB = 6;
  localparam int YB = 3;
  localparam int CS = 4;
  localparam int AB = 8;

  logic          clk = 1'b0;
  logic          rst, start, abort, reload_ids;
  logic [R-2:0]  ln_cfg;
  logic [CS-1:0] pe_cfg;
  logic [N-1:0]  pe_en_mask;
  logic          busy, done, id_rd_en, set_YID, set_XID, set_LN;
  logic [AB-1:0] id_rd_addr;
  logic [4*XB-1:0] id_rd_data;
  logic [YB-1:0] ify, fly, ipy, opy;
  logic [XB-1:0] ifx, flx, ipx, opx;
  logic [R-2:0]  LN_config_out;
  logic [N-1:0]  PE_en;
  logic [CS-1:0] PE_config;

  pe_array_cfg_seq dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .reload_ids(reload_ids), .ln_cfg(ln_cfg), .pe_cfg(pe_cfg),
    .pe_en_mask(pe_en_mask), .busy(busy), .done(done),
    .id_rd_en(id_rd_en), .id_rd_addr(id_rd_addr), .id_rd_data(id_rd_data),
    .set_YID(set_YID), .set_XID(set_XID),
    .ifmap_YID_scan_out(ify), .filter_YID_scan_out(fly),
    .ipsum_YID_scan_out(ipy), .opsum_YID_scan_out(opy),
    .ifmap_XID_scan_out(ifx), .filter_XID_scan_out(flx),
    .ipsum_XID_scan_out(ipx), .opsum_XID_scan_out(opx),
    .set_LN(set_LN), .LN_config_out(LN_config_out),
    .PE_en(PE_en), .PE_config(PE_config)
  );

  always #5 clk = ~clk;

  id_entry_t ram [256];
  id_entry_t rd_q;
  assign id_rd_data = rd_q;
  always @(posedge clk) if (id_rd_en) rd_q <= ram[id_rd_addr];

  int n_pass  = 0;
  int n_total = 0;

  bit            cur_reload;
  int            ab_k, rs_k;
  logic [R-2:0]  exp_ln;
  logic [CS-1:0] exp_pe;
  logic [N-1:0]  exp_mask;

  task automatic chk(input string tag, input int k,
                     input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // k = cycles since start was sampled
  task automatic check_cycle(input int k);
    bit rdead, dead, rd, sy, sx;
    int ln_k;
    id_entry_t e;
    rdead = (rs_k > 0 && k > rs_k);
    dead  = rdead || (ab_k > 0 && k > ab_k);
    ln_k  = cur_reload ? R + N + 2 : 1;
    rd = cur_reload && k >= 1 && k <= R + N && !dead;
    sy = cur_reload && k >= 2 && k <= R + 1 && !dead;
    sx = cur_reload && k >= R + 2 && k <= R + N + 1 && !dead;
    e  = (sy || sx) ? ram[k-2] : '0;
    chk("busy", k, 64'(busy), 64'(k >= 1 && k <= ln_k + 2 && !dead));
    chk("done", k, 64'(done), 64'(k == ln_k + 2 && !dead));
    chk("rd_en", k, 64'(id_rd_en), 64'(rd));
    chk("rd_addr", k, 64'(id_rd_addr), rd ? 64'(k - 1) : 64'd0);
    chk("set_YID", k, 64'(set_YID), 64'(sy));
    chk("set_XID", k, 64'(set_XID), 64'(sx));
    chk("ifmap_Y", k, 64'(ify), sy ? 64'(e.ifmap[YB-1:0]) : 64'd0);
    chk("filter_Y", k, 64'(fly), sy ? 64'(e.filter[YB-1:0]) : 64'd0);
    chk("ipsum_Y", k, 64'(ipy), sy ? 64'(e.ipsum[YB-1:0]) : 64'd0);
    chk("opsum_Y", k, 64'(opy), sy ? 64'(e.opsum[YB-1:0]) : 64'd0);
    chk("ifmap_X", k, 64'(ifx), sx ? 64'(e.ifmap) : 64'd0);
    chk("filter_X", k, 64'(flx), sx ? 64'(e.filter) : 64'd0);
    chk("ipsum_X", k, 64'(ipx), sx ? 64'(e.ipsum) : 64'd0);
    chk("opsum_X", k, 64'(opx), sx ? 64'(e.opsum) : 64'd0);
    chk("set_LN", k, 64'(set_LN), 64'(k == ln_k && !dead));
    chk("LN_cfg", k, 64'(LN_config_out), rdead ? 64'd0 : 64'(exp_ln));
    chk("PE_en", k, 64'(PE_en),
        (k == ln_k + 1 && !dead) ? 64'(exp_mask) : 64'd0);
    chk("PE_cfg", k, 64'(PE_config), rdead ? 64'd0 : 64'(exp_pe));
  endtask

  // entered at a negedge with the DUT idle; that cycle is cycle 0
  task automatic run(input bit rl, input int ab, input int rs,
                     input int x1, input int x2,
                     input logic [R-2:0] ln, input logic [CS-1:0] pe,
                     input logic [N-1:0] mask, input int ncyc);
    cur_reload = rl; ab_k = ab; rs_k = rs;
    exp_ln = ln; exp_pe = pe; exp_mask = mask;
    ln_cfg = ln; pe_cfg = pe; pe_en_mask = mask;
    reload_ids = rl; start = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; rst = 1'b0;
      check_cycle(k);
      ln_cfg     = (R-1)'($urandom);
      pe_cfg     = CS'($urandom);
      pe_en_mask = N'({$urandom, $urandom});
      reload_ids = 1'($urandom);
      if (k == x1 || k == x2) start = 1'b1;
      if (k == ab) begin
        abort = 1'b1;
        start = 1'b1;
      end
      if (k == rs) rst = 1'b1;
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; reload_ids = 1'b0;
    ln_cfg = '0; pe_cfg = '0; pe_en_mask = '0;
    for (int i = 0; i < 256; i++)
      ram[i] = '{opsum: XB'(i), ipsum: XB'(i), filter: XB'(i), ifmap: XB'(i)};

    repeat (3) @(negedge clk);
    cur_reload = 1'b0; ab_k = 0; rs_k = 1;
    exp_ln = '0; exp_pe = '0; exp_mask = '0;
    check_cycle(1000);
    rst = 1'b0;
    @(negedge clk);

    run(1'b1, 0, 0, 0, 0, (R-1)'($urandom), CS'($urandom),
        N'({$urandom, $urandom}), 60);

    run(1'b0, 0, 0, 0, 0, 5'b10110, {1'b1, 3'($urandom)}, '1, 6);

    run(1'b1, 20, 0, 0, 0, (R-1)'($urandom), CS'($urandom),
        N'({$urandom, $urandom}), 25);
    run(1'b1, 0, 0, 0, 0, (R-1)'($urandom), CS'($urandom),
        N'({$urandom, $urandom}), 60);

    for (int i = 0; i < 256; i++) ram[i] = 24'($urandom);
    run(1'b1, 0, 0, 10, 30, (R-1)'($urandom), CS'($urandom),
        N'({$urandom, $urandom}), 60);

    run(1'b1, 0, 3, 0, 0, (R-1)'($urandom), CS'($urandom),
        N'({$urandom, $urandom}), 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
